// File: rtl/uvmt_cv32e40x_pma_obi_checker.sv
// uvmt_cv32e40x_pma_obi_checker: checks OBI address-phase PMA legality, memtype, stability and outstanding-transaction accounting.
// Ports: clk/rst_n (async active-low); obi_* monitored OBI master port; pma_* PMA model verdict for obi_addr;
// err_*_o registered one-cycle violation pulses; outstanding_o FIFO occupancy; cnt_*_o saturating event counters.
module uvmt_cv32e40x_pma_obi_checker #(
  parameter bit IS_INSTR_SIDE   = 1'b0,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obi_req,
  input  logic             obi_gnt,
  input  logic [31:0]      obi_addr,
  input  logic             obi_we,
  input  logic [1:0]       obi_memtype,
  input  logic [5:0]       obi_atop,
  input  logic             obi_rvalid,
  input  logic             obi_err,
  input  logic             pma_allow,
  input  logic             pma_bufferable,
  input  logic             pma_cacheable,
  input  logic             pma_override_dm,
  output logic             err_disallowed_o,
  output logic             err_memtype_o,
  output logic             err_unstable_o,
  output logic             err_overflow_o,
  output logic             err_unexp_rvalid_o,
  output logic [2:0]       outstanding_o,
  output logic [CNT_W-1:0] cnt_accepted_o,
  output logic [CNT_W-1:0] cnt_resp_err_o,
  output logic [CNT_W-1:0] cnt_dm_override_o
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_GNT = 1'b1;
  localparam logic [2:0] MAX_OCC  = 3'(MAX_OUTSTANDING);
  logic [0:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [1:0]       memtype_q, memtype_d;
  logic [5:0]       atop_q, atop_d;
  logic             err_disallowed_q, err_disallowed_d;
  logic             err_memtype_q, err_memtype_d;
  logic             err_unstable_q, err_unstable_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_unexp_q, err_unexp_d;
  logic [2:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_acc_q, cnt_acc_d;
  logic [CNT_W-1:0] cnt_rerr_q, cnt_rerr_d;
  logic [CNT_W-1:0] cnt_dm_q, cnt_dm_d;
  logic             accept, stall, push, pop;
  always_comb begin
    accept           = obi_req && obi_gnt;
    stall            = obi_req && !obi_gnt;
    state_d          = (state_q == IDLE) ? (stall ? WAIT_GNT : IDLE) : (stall ? WAIT_GNT : IDLE);
    // Capture the address phase only when a wait for grant begins; it is the reference for stability.
    addr_d           = (state_q == IDLE && stall) ? obi_addr    : addr_q;
    we_d             = (state_q == IDLE && stall) ? obi_we      : we_q;
    memtype_d        = (state_q == IDLE && stall) ? obi_memtype : memtype_q;
    atop_d           = (state_q == IDLE && stall) ? obi_atop    : atop_q;
    err_unstable_d   = (state_q == WAIT_GNT) && (!obi_req || obi_addr != addr_q || obi_we != we_q ||
                       obi_memtype != memtype_q || obi_atop != atop_q);
    err_disallowed_d = accept && (!pma_allow || (IS_INSTR_SIDE && (obi_we || |obi_atop)));
    err_memtype_d    = accept && (obi_memtype != {pma_cacheable, pma_bufferable});
    err_unexp_d      = obi_rvalid && (occ_q == 3'd0);
    err_overflow_d   = accept && (occ_q == MAX_OCC) && !obi_rvalid;
    // Only occupancy is observable, so the FIFO is tracked as a count of stored entries.
    push             = accept && !err_overflow_d;
    pop              = obi_rvalid && !err_unexp_d;
    occ_d            = occ_q + 3'(push) - 3'(pop);
    cnt_acc_d        = (accept && ~&cnt_acc_q) ? cnt_acc_q + CNT_W'(1) : cnt_acc_q;
    cnt_rerr_d       = (obi_rvalid && obi_err && ~&cnt_rerr_q) ? cnt_rerr_q + CNT_W'(1) : cnt_rerr_q;
    cnt_dm_d         = (accept && pma_override_dm && ~&cnt_dm_q) ? cnt_dm_q + CNT_W'(1) : cnt_dm_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      we_q             <= 1'b0;
      memtype_q        <= '0;
      atop_q           <= '0;
      err_disallowed_q <= 1'b0;
      err_memtype_q    <= 1'b0;
      err_unstable_q   <= 1'b0;
      err_overflow_q   <= 1'b0;
      err_unexp_q      <= 1'b0;
      occ_q            <= '0;
      cnt_acc_q        <= '0;
      cnt_rerr_q       <= '0;
      cnt_dm_q         <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      we_q             <= we_d;
      memtype_q        <= memtype_d;
      atop_q           <= atop_d;
      err_disallowed_q <= err_disallowed_d;
      err_memtype_q    <= err_memtype_d;
      err_unstable_q   <= err_unstable_d;
      err_overflow_q   <= err_overflow_d;
      err_unexp_q      <= err_unexp_d;
      occ_q            <= occ_d;
      cnt_acc_q        <= cnt_acc_d;
      cnt_rerr_q       <= cnt_rerr_d;
      cnt_dm_q         <= cnt_dm_d;
    end
  end
  assign err_disallowed_o   = err_disallowed_q;
  assign err_memtype_o      = err_memtype_q;
  assign err_unstable_o     = err_unstable_q;
  assign err_overflow_o     = err_overflow_q;
  assign err_unexp_rvalid_o = err_unexp_q;
  assign outstanding_o      = occ_q;
  assign cnt_accepted_o     = cnt_acc_q;
  assign cnt_resp_err_o     = cnt_rerr_q;
  assign cnt_dm_override_o  = cnt_dm_q;
endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_checker.sv
// tb_uvmt_cv32e40x_pma_obi_checker: directed self-checking bench for data-side and instruction-side checkers.
module tb_uvmt_cv32e40x_pma_obi_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 0, gnt = 0, we = 0, rvalid = 0, err = 0;
  logic allow = 1, bufb = 0, cach = 0, dm = 0;
  logic [31:0] addr = '0;
  logic [1:0] memtype = '0;
  logic [5:0] atop = '0;
  logic d_dis, d_mt, d_uns, d_ovf, d_unx;
  logic [2:0] d_occ;
  logic [31:0] d_acc, d_rerr, d_dm;
  logic i_dis, i_mt, i_uns, i_ovf, i_unx;
  logic [2:0] i_occ;
  logic [3:0] i_acc, i_rerr, i_dm;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  uvmt_cv32e40x_pma_obi_checker #(.IS_INSTR_SIDE(1'b0), .MAX_OUTSTANDING(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .obi_req(req), .obi_gnt(gnt), .obi_addr(addr), .obi_we(we),
    .obi_memtype(memtype), .obi_atop(atop), .obi_rvalid(rvalid), .obi_err(err), .pma_allow(allow),
    .pma_bufferable(bufb), .pma_cacheable(cach), .pma_override_dm(dm),
    .err_disallowed_o(d_dis), .err_memtype_o(d_mt), .err_unstable_o(d_uns), .err_overflow_o(d_ovf),
    .err_unexp_rvalid_o(d_unx), .outstanding_o(d_occ), .cnt_accepted_o(d_acc),
    .cnt_resp_err_o(d_rerr), .cnt_dm_override_o(d_dm));
  uvmt_cv32e40x_pma_obi_checker #(.IS_INSTR_SIDE(1'b1), .MAX_OUTSTANDING(2), .CNT_W(4)) dut_i (
    .clk(clk), .rst_n(rst_n), .obi_req(req), .obi_gnt(gnt), .obi_addr(addr), .obi_we(we),
    .obi_memtype(memtype), .obi_atop(atop), .obi_rvalid(rvalid), .obi_err(err), .pma_allow(allow),
    .pma_bufferable(bufb), .pma_cacheable(cach), .pma_override_dm(dm),
    .err_disallowed_o(i_dis), .err_memtype_o(i_mt), .err_unstable_o(i_uns), .err_overflow_o(i_ovf),
    .err_unexp_rvalid_o(i_unx), .outstanding_o(i_occ), .cnt_accepted_o(i_acc),
    .cnt_resp_err_o(i_rerr), .cnt_dm_override_o(i_dm));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_errs"}, {27'd0, d_dis, d_mt, d_uns, d_ovf, d_unx}, 32'd0);
    chk({tag, "_occ"}, {29'd0, d_occ}, 32'd0);
    chk({tag, "_cnts"}, d_acc | d_rerr | d_dm, 32'd0);
  endtask
  initial begin
    #1;
    chk_all_zero("reset_state");
    tick();
    tick();
    rst_n = 1'b1;
    // Clean data-side accept, then its response.
    req = 1; gnt = 1; addr = 32'h0000_1000; memtype = 2'b01; bufb = 1; cach = 0; allow = 1;
    tick();
    chk("ok_disallowed", {31'd0, d_dis}, 32'd0);
    chk("ok_memtype", {31'd0, d_mt}, 32'd0);
    chk("ok_cnt_acc", d_acc, 32'd1);
    chk("ok_occ", {29'd0, d_occ}, 32'd1);
    req = 0; gnt = 0; rvalid = 1;
    tick();
    chk("ok_resp_occ", {29'd0, d_occ}, 32'd0);
    chk("ok_resp_unexp", {31'd0, d_unx}, 32'd0);
    rvalid = 0;
    // Disallowed accept, then memtype mismatch.
    req = 1; gnt = 1; addr = 32'h0000_2000; memtype = 2'b00; bufb = 0; cach = 0; allow = 0;
    tick();
    chk("dis_pulse", {31'd0, d_dis}, 32'd1);
    chk("dis_no_mt", {31'd0, d_mt}, 32'd0);
    allow = 1; memtype = 2'b10;
    tick();
    chk("mt_pulse", {31'd0, d_mt}, 32'd1);
    chk("mt_no_dis", {31'd0, d_dis}, 32'd0);
    chk("mt_cnt_acc", d_acc, 32'd3);
    req = 0; gnt = 0; memtype = 2'b00; rvalid = 1;
    tick();
    chk("mt_pulse_clears", {31'd0, d_mt}, 32'd0);
    tick();
    chk("drain_occ", {29'd0, d_occ}, 32'd0);
    rvalid = 0;
    // Address changes while waiting for grant.
    req = 1; gnt = 0; addr = 32'h100;
    tick();
    chk("uns_first", {31'd0, d_uns}, 32'd0);
    addr = 32'h104;
    tick();
    chk("uns_pulse", {31'd0, d_uns}, 32'd1);
    chk("uns_no_push", {29'd0, d_occ}, 32'd0);
    tick();
    chk("uns_still_no_push", {29'd0, d_occ}, 32'd0);
    gnt = 1;
    tick();
    chk("uns_gnt_occ", {29'd0, d_occ}, 32'd1);
    chk("uns_gnt_acc", d_acc, 32'd4);
    chk("uns_gnt_changed", {31'd0, d_uns}, 32'd1);
    req = 0; gnt = 0; rvalid = 1;
    tick();
    chk("uns_idle", {31'd0, d_uns}, 32'd0);
    chk("uns_drain", {29'd0, d_occ}, 32'd0);
    rvalid = 0;
    // Request dropped while waiting for grant.
    req = 1; addr = 32'h200;
    tick();
    req = 0;
    tick();
    chk("drop_pulse", {31'd0, d_uns}, 32'd1);
    tick();
    chk("drop_clears", {31'd0, d_uns}, 32'd0);
    // Overflow and full-with-response.
    req = 1; gnt = 1; addr = 32'h0000_3000;
    tick();
    chk("ovf_occ1", {29'd0, d_occ}, 32'd1);
    tick();
    chk("ovf_occ2", {29'd0, d_occ}, 32'd2);
    chk("ovf_none_yet", {31'd0, d_ovf}, 32'd0);
    tick();
    chk("ovf_pulse", {31'd0, d_ovf}, 32'd1);
    chk("ovf_occ_sat", {29'd0, d_occ}, 32'd2);
    rvalid = 1;
    tick();
    chk("full_pp_ovf", {31'd0, d_ovf}, 32'd0);
    chk("full_pp_unexp", {31'd0, d_unx}, 32'd0);
    chk("full_pp_occ", {29'd0, d_occ}, 32'd2);
    req = 0; gnt = 0; err = 1;
    tick();
    chk("rerr_cnt", d_rerr, 32'd1);
    chk("rerr_occ", {29'd0, d_occ}, 32'd1);
    err = 0;
    tick();
    chk("empty_occ", {29'd0, d_occ}, 32'd0);
    tick();
    chk("unexp_pulse", {31'd0, d_unx}, 32'd1);
    chk("unexp_occ", {29'd0, d_occ}, 32'd0);
    req = 1; gnt = 1;
    tick();
    chk("empty_pp_unexp", {31'd0, d_unx}, 32'd1);
    chk("empty_pp_occ", {29'd0, d_occ}, 32'd1);
    req = 0; gnt = 0;
    tick();
    chk("empty_pp_drain", {29'd0, d_occ}, 32'd0);
    chk("total_acc", d_acc, 32'd9);
    chk("i_acc_sat", {28'd0, i_acc}, 32'd9);
    rvalid = 0;
    // Asynchronous reset with two outstanding and a request pending.
    req = 1; gnt = 1; addr = 32'h0000_4000;
    tick();
    tick();
    chk("rst_pre_occ", {29'd0, d_occ}, 32'd2);
    gnt = 0;
    tick();
    #2;
    rst_n = 0;
    #1;
    chk_all_zero("rst_async");
    tick();
    chk_all_zero("rst_held");
    rst_n = 1; req = 0; rvalid = 1;
    tick();
    chk("rst_unexp", {31'd0, d_unx}, 32'd1);
    chk("rst_unexp_occ", {29'd0, d_occ}, 32'd0);
    rvalid = 0;
    // Instruction side: writes and atomics are illegal; dm-override counter saturates.
    req = 1; gnt = 1; we = 1; addr = 32'h0000_5000;
    tick();
    chk("instr_we_dis", {31'd0, i_dis}, 32'd1);
    chk("data_we_ok", {31'd0, d_dis}, 32'd0);
    we = 0; atop = 6'h01;
    tick();
    chk("instr_atop_dis", {31'd0, i_dis}, 32'd1);
    atop = 6'h00; dm = 1; rvalid = 1;
    tick();
    chk("instr_ok", {31'd0, i_dis}, 32'd0);
    chk("instr_no_ovf", {31'd0, i_ovf}, 32'd0);
    for (int k = 1; k < 15; k++) tick();
    chk("dm_at_15", {28'd0, i_dm}, 32'd15);
    tick();
    tick();
    chk("dm_sat_17", {28'd0, i_dm}, 32'd15);
    chk("acc_sat_i", {28'd0, i_acc}, 32'd15);
    chk("dm_data_17", d_dm, 32'd17);
    chk("instr_occ_full", {29'd0, i_occ}, 32'd2);
    req = 0; gnt = 0; rvalid = 0; dm = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uvmt_cv32e40x_pma_obi_checker.md
Name: uvmt_cv32e40x_pma_obi_checker

Overview:
- Consumes the per-access PMA status produced by the PMA model.
- Monitors one OBI master port of the core: instruction side or data side, chosen by a parameter.
- Checks that every OBI address-phase transaction the core issues is PMA-legal and carries the correct memtype attribute.
- Tracks outstanding transactions until their response, and flags protocol and attribute violations as registered pulses, with counters for coverage and scoreboarding.

Parameters:
- IS_INSTR_SIDE, 0, 1 = instruction port (write and atomic checks disabled); 0 = data port.
- MAX_OUTSTANDING, 2, depth of the outstanding-transaction FIFO; legal range 1..4.
- CNT_W, 32, width of the saturating event counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- obi_req  input  1  OBI address-phase request.
- obi_gnt  input  1  OBI grant.
- obi_addr  input  32  request address.
- obi_we  input  1  write enable.
- obi_memtype  input  2  [0] bufferable, [1] cacheable.
- obi_atop  input  6  atomic opcode; nonzero = atomic.
- obi_rvalid  input  1  response valid.
- obi_err  input  1  response bus error.
- pma_allow  input  1  PMA model allow for current obi_addr.
- pma_bufferable  input  1  PMA model bufferable.
- pma_cacheable  input  1  PMA model cacheable.
- pma_override_dm  input  1  PMA model debug-region override.
- err_disallowed_o  output  1  pulse: accepted transaction had pma_allow=0.
- err_memtype_o  output  1  pulse: memtype differs from PMA bufferable/cacheable.
- err_unstable_o  output  1  pulse: address-phase signals changed while waiting for grant.
- err_overflow_o  output  1  pulse: accept with FIFO full and no simultaneous response.
- err_unexp_rvalid_o  output  1  pulse: rvalid with FIFO empty.
- outstanding_o  output  3  current FIFO occupancy.
- cnt_accepted_o  output  CNT_W  accepted transactions.
- cnt_resp_err_o  output  CNT_W  responses with obi_err=1.
- cnt_dm_override_o  output  CNT_W  accepted transactions with pma_override_dm=1.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE. Asynchronous on rst_n low; takes effect mid-transaction and discards all outstanding entries.
- Accept = obi_req && obi_gnt. Response = obi_rvalid.
- FSM IDLE / WAIT_GNT:
  - IDLE -> WAIT_GNT when obi_req && !obi_gnt; latches addr, we, memtype, atop.
  - WAIT_GNT -> IDLE on accept, or if obi_req drops (drop is itself a stability violation).
  - In WAIT_GNT, any difference between latched and current addr/we/memtype/atop, or obi_req=0, raises err_unstable_o one cycle later.
- On accept, all pulses are registered and asserted exactly one cycle after the accept edge:
  - err_disallowed_o = !pma_allow.
  - err_memtype_o = (obi_memtype[0] != pma_bufferable) || (obi_memtype[1] != pma_cacheable).
  - IS_INSTR_SIDE=1 additionally flags err_disallowed_o if obi_we || obi_atop != 0.
- FIFO:
  - Accept pushes {we, atomic, addr}; response pops the oldest entry.
  - Simultaneous push and pop: occupancy unchanged, legal even when full.
  - Push when full without pop: entry dropped, err_overflow_o, occupancy stays MAX_OUTSTANDING.
  - Pop when empty: err_unexp_rvalid_o, occupancy stays 0.
  - Simultaneous push and pop when empty: pop is unexpected, push is stored, occupancy becomes 1.
- outstanding_o is registered; it reflects occupancy after the current cycle's push/pop on the next cycle.
- Counters are registered, increment by 1 per qualifying event, and saturate at all-ones (no wrap).
  - cnt_resp_err_o counts obi_rvalid && obi_err.
- Multiple error pulses may assert in the same cycle; they are independent.

Test Plan:
- Reset mid-traffic (2 outstanding, req pending) -> next cycle all outputs 0, outstanding_o=0; subsequent rvalid raises err_unexp_rvalid_o.
- Data-side accept at addr 0x0000_1000, pma_allow=1, pma_bufferable=1, memtype=2'b01 -> no error; cnt_accepted_o=1; outstanding_o=1; rvalid next cycle -> outstanding_o=0.
- Accept with pma_allow=0, then accept with memtype=2'b10 while pma_cacheable=0 -> err_disallowed_o one cycle after the first, err_memtype_o one cycle after the second.
- req held 3 cycles without gnt, addr changes 0x100 -> 0x104 in cycle 2 -> err_unstable_o one cycle later; no FIFO push until gnt.
- MAX_OUTSTANDING=2: three accepts without rvalid -> err_overflow_o on the third; then accept together with rvalid while full -> no error, occupancy stays 2.
- IS_INSTR_SIDE=1, accept with obi_we=1 -> err_disallowed_o. Then 2^CNT_W+1 accepts with CNT_W=4 and pma_override_dm=1 -> cnt_dm_override_o saturates at 15.
